// File: rtl/sub_pkg.sv
// Shared definitions for the serial subtractor: FSM state encodings and a
// helper that sizes the slice index counter.
package sub_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Bits needed to count 0..n-1, never less than one so that a
  // single-slice configuration still gets a legal counter.
  function automatic int idx_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/chunk_sub.sv
// CHUNK-bit combinational subtractor slice: d = x - y - bi, bo = borrow-out.
// Built as a ripple of single-bit full-subtractor cells.
module chunk_sub #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             bi,
  output logic [CHUNK-1:0] d,
  output logic             bo
);

  logic [CHUNK:0] borrow;

  assign borrow[0] = bi;

  // Each cell borrows when x < y + borrow-in at its bit position.
  for (genvar i = 0; i < CHUNK; i++) begin : g_cell
    assign d[i]          = x[i] ^ y[i] ^ borrow[i];
    assign borrow[i + 1] = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & borrow[i]);
  end

  assign bo = borrow[CHUNK];

endmodule

// File: rtl/serial_subtractor.sv
// Multi-cycle WIDTH-bit subtractor computing a - b - bin one CHUNK-bit slice
// per clock, LSB slice first, with a registered borrow between slices.
// A single chunk_sub instance is shared across slices via the slice index.
module serial_subtractor
  import sub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = idx_width(NCHUNK);
  localparam int MSB    = WIDTH - 1;

  localparam logic [IDXW-1:0]  LAST_IDX   = IDXW'(NCHUNK - 1);
  localparam logic [WIDTH-1:0] SLICE_MASK = WIDTH'({CHUNK{1'b1}});

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic             borrow_q, borrow_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;

  logic [CHUNK-1:0] slice_x;
  logic [CHUNK-1:0] slice_y;
  logic [CHUNK-1:0] slice_d;
  logic             slice_bo;
  logic [WIDTH-1:0] diff_merged;
  int               shamt;

  // Pick the operand slice addressed by the index and splice the slice
  // result back into the running difference at the same position.
  always_comb begin
    shamt       = int'(idx_q) * CHUNK;
    slice_x     = CHUNK'(a_q >> shamt);
    slice_y     = CHUNK'(b_q >> shamt);
    diff_merged = (diff_q & ~(SLICE_MASK << shamt)) | (WIDTH'(slice_d) << shamt);
  end

  chunk_sub #(
    .CHUNK(CHUNK)
  ) u_chunk_sub (
    .x (slice_x),
    .y (slice_y),
    .bi(borrow_q),
    .d (slice_d),
    .bo(slice_bo)
  );

  // FSM and datapath next-state: accept in IDLE, one slice per RUN cycle,
  // hold results in DONE until the consumer takes them.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    diff_d   = diff_q;
    idx_d    = idx_q;
    borrow_d = borrow_q;
    bout_d   = bout_q;
    ovf_d    = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d      = a;
          b_d      = b;
          borrow_d = bin;
          idx_d    = '0;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        diff_d   = diff_merged;
        borrow_d = slice_bo;
        if (idx_q == LAST_IDX) begin
          state_d = ST_DONE;
          bout_d  = slice_bo;
          ovf_d   = (a_q[MSB] ^ b_q[MSB]) & (a_q[MSB] ^ diff_merged[MSB]);
        end else begin
          idx_d = idx_q + IDXW'(1);
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; reset discards any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      diff_q   <= '0;
      idx_q    <= '0;
      borrow_q <= 1'b0;
      bout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      diff_q   <= diff_d;
      idx_q    <= idx_d;
      borrow_q <= borrow_d;
      bout_q   <= bout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign diff      = diff_q;
  assign bout      = bout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: one instance per slice width
// (CHUNK = 4, 1, 16) with WIDTH = 16, expected values computed by hand.
module tb_serial_subtractor;

  logic        clk;
  logic        rst_n;
  logic [15:0] a;
  logic [15:0] b;
  logic        bin;
  logic        inValid   [3];
  logic        outReady  [3];
  logic        inReady   [3];
  logic        outValid  [3];
  logic [15:0] diffO     [3];
  logic        boutO     [3];
  logic        ovfO      [3];

  int checkCount;
  int errCount;

  serial_subtractor #(.WIDTH(16), .CHUNK(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid[0]), .in_ready(inReady[0]),
    .a(a), .b(b), .bin(bin), .out_valid(outValid[0]), .out_ready(outReady[0]),
    .diff(diffO[0]), .bout(boutO[0]), .ovf(ovfO[0])
  );

  serial_subtractor #(.WIDTH(16), .CHUNK(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid[1]), .in_ready(inReady[1]),
    .a(a), .b(b), .bin(bin), .out_valid(outValid[1]), .out_ready(outReady[1]),
    .diff(diffO[1]), .bout(boutO[1]), .ovf(ovfO[1])
  );

  serial_subtractor #(.WIDTH(16), .CHUNK(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid[2]), .in_ready(inReady[2]),
    .a(a), .b(b), .bin(bin), .out_valid(outValid[2]), .out_ready(outReady[2]),
    .diff(diffO[2]), .bout(boutO[2]), .ovf(ovfO[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present operands to instance u for one accept edge; returns 1 cycle
  // after that edge with in_valid dropped again.
  task automatic startOp(input int u, input logic [15:0] av, input logic [15:0] bv,
                         input logic bi);
    a = av;
    b = bv;
    bin = bi;
    inValid[u] = 1'b1;
    @(posedge clk);
    #1;
    inValid[u] = 1'b0;
  endtask

  // Count edges until out_valid, bounded so a stuck DUT still ends the run.
  task automatic waitDone(input int u, output int cycles);
    cycles = 0;
    while (!outValid[u] && cycles < 100) begin
      @(posedge clk);
      #1;
      cycles++;
    end
  endtask

  // Single-cycle output handshake.
  task automatic retireOp(input int u);
    outReady[u] = 1'b1;
    @(posedge clk);
    #1;
    outReady[u] = 1'b0;
  endtask

  task automatic test_reset();
    @(posedge clk);
    #1;
    checkCount++;
    if (inReady[0] !== 1'b1) begin
      errCount++; $display("[TB] FAIL reset_in_ready got %b expected 1", inReady[0]);
    end
    checkCount++;
    if (outValid[0] !== 1'b0) begin
      errCount++; $display("[TB] FAIL reset_out_valid got %b expected 0", outValid[0]);
    end
    checkCount++;
    if ({diffO[0], boutO[0], ovfO[0]} !== 18'h0) begin
      errCount++;
      $display("[TB] FAIL reset_outputs got diff=%h bout=%b ovf=%b expected 0", diffO[0],
               boutO[0], ovfO[0]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    int cyc;
    startOp(0, 16'h1234, 16'h0234, 1'b0);
    waitDone(0, cyc);
    checkCount++;
    if (cyc !== 4) begin
      errCount++; $display("[TB] FAIL basic_latency got %0d expected 4", cyc);
    end
    checkCount++;
    if (diffO[0] !== 16'h1000) begin
      errCount++; $display("[TB] FAIL basic_diff got %h expected 1000", diffO[0]);
    end
    checkCount++;
    if ({boutO[0], ovfO[0]} !== 2'b00) begin
      errCount++; $display("[TB] FAIL basic_flags got %b%b expected 00", boutO[0], ovfO[0]);
    end
    retireOp(0);
    checkCount++;
    if ({inReady[0], outValid[0]} !== 2'b10) begin
      errCount++;
      $display("[TB] FAIL basic_retire got in_ready=%b out_valid=%b expected 1 0", inReady[0],
               outValid[0]);
    end
  endtask

  task automatic test_underflow();
    int cyc;
    startOp(0, 16'h0000, 16'h0001, 1'b0);
    waitDone(0, cyc);
    checkCount++;
    if ({diffO[0], boutO[0], ovfO[0]} !== {16'hFFFF, 1'b1, 1'b0}) begin
      errCount++;
      $display("[TB] FAIL underflow got diff=%h bout=%b ovf=%b expected FFFF 1 0", diffO[0],
               boutO[0], ovfO[0]);
    end
    retireOp(0);
  endtask

  task automatic test_borrow_in();
    int cyc;
    startOp(0, 16'h0005, 16'h0005, 1'b1);
    waitDone(0, cyc);
    checkCount++;
    if ({diffO[0], boutO[0], ovfO[0]} !== {16'hFFFF, 1'b1, 1'b0}) begin
      errCount++;
      $display("[TB] FAIL borrow_in got diff=%h bout=%b ovf=%b expected FFFF 1 0", diffO[0],
               boutO[0], ovfO[0]);
    end
    retireOp(0);
  endtask

  task automatic test_overflow();
    int cyc;
    startOp(0, 16'h8000, 16'h0001, 1'b0);
    waitDone(0, cyc);
    checkCount++;
    if ({diffO[0], boutO[0], ovfO[0]} !== {16'h7FFF, 1'b0, 1'b1}) begin
      errCount++;
      $display("[TB] FAIL overflow got diff=%h bout=%b ovf=%b expected 7FFF 0 1", diffO[0],
               boutO[0], ovfO[0]);
    end
    retireOp(0);
  endtask

  task automatic test_backpressure();
    int cyc;
    int bad;
    startOp(0, 16'h00FF, 16'h0001, 1'b0);
    waitDone(0, cyc);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      a = 16'h0100 + 16'(i);
      b = 16'h0003;
      bin = 1'b1;
      inValid[0] = 1'b1;
      @(posedge clk);
      #1;
      if ({outValid[0], inReady[0], diffO[0], boutO[0], ovfO[0]} !==
          {1'b1, 1'b0, 16'h00FE, 1'b0, 1'b0}) begin
        bad++;
        $display("[TB] FAIL backpressure_hold cycle %0d got v=%b r=%b diff=%h expected 1 0 00FE",
                 i, outValid[0], inReady[0], diffO[0]);
      end
    end
    inValid[0] = 1'b0;
    checkCount++;
    if (bad != 0) errCount++;
    retireOp(0);
    checkCount++;
    if ({inReady[0], outValid[0]} !== 2'b10) begin
      errCount++;
      $display("[TB] FAIL backpressure_release got in_ready=%b out_valid=%b expected 1 0",
               inReady[0], outValid[0]);
    end
    repeat (6) @(posedge clk);
    #1;
    checkCount++;
    if ({inReady[0], outValid[0]} !== 2'b10) begin
      errCount++;
      $display("[TB] FAIL backpressure_no_second_accept got in_ready=%b out_valid=%b expected 1 0",
               inReady[0], outValid[0]);
    end
  endtask

  task automatic test_reset_mid_run();
    int cyc;
    startOp(0, 16'hAAAA, 16'h1111, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkCount++;
    if ({inReady[0], outValid[0], diffO[0]} !== {1'b1, 1'b0, 16'h0000}) begin
      errCount++;
      $display("[TB] FAIL reset_mid_run got r=%b v=%b diff=%h expected 1 0 0000", inReady[0],
               outValid[0], diffO[0]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    startOp(0, 16'h00FF, 16'h000F, 1'b0);
    waitDone(0, cyc);
    checkCount++;
    if ({cyc, diffO[0], boutO[0]} !== {32'd4, 16'h00F0, 1'b0}) begin
      errCount++;
      $display("[TB] FAIL after_reset_op got cycles=%0d diff=%h bout=%b expected 4 00F0 0", cyc,
               diffO[0], boutO[0]);
    end
    retireOp(0);
  endtask

  task automatic test_chunk_sweep();
    int cyc;
    startOp(1, 16'h1234, 16'h0234, 1'b0);
    waitDone(1, cyc);
    checkCount++;
    if ({cyc, diffO[1], boutO[1], ovfO[1]} !== {32'd16, 16'h1000, 1'b0, 1'b0}) begin
      errCount++;
      $display("[TB] FAIL chunk1 got cycles=%0d diff=%h bout=%b ovf=%b expected 16 1000 0 0",
               cyc, diffO[1], boutO[1], ovfO[1]);
    end
    retireOp(1);
    startOp(2, 16'h1234, 16'h0234, 1'b0);
    waitDone(2, cyc);
    checkCount++;
    if ({cyc, diffO[2], boutO[2], ovfO[2]} !== {32'd1, 16'h1000, 1'b0, 1'b0}) begin
      errCount++;
      $display("[TB] FAIL chunk16 got cycles=%0d diff=%h bout=%b ovf=%b expected 1 1000 0 0",
               cyc, diffO[2], boutO[2], ovfO[2]);
    end
    retireOp(2);
    startOp(2, 16'h8000, 16'h0001, 1'b0);
    waitDone(2, cyc);
    checkCount++;
    if ({diffO[2], boutO[2], ovfO[2]} !== {16'h7FFF, 1'b0, 1'b1}) begin
      errCount++;
      $display("[TB] FAIL chunk16_overflow got diff=%h bout=%b ovf=%b expected 7FFF 0 1",
               diffO[2], boutO[2], ovfO[2]);
    end
    retireOp(2);
  endtask

  // Run every scenario in order, then report.
  initial begin
    checkCount = 0;
    errCount = 0;
    rst_n = 1'b0;
    a = '0;
    b = '0;
    bin = 1'b0;
    for (int i = 0; i < 3; i++) begin
      inValid[i] = 1'b0;
      outReady[i] = 1'b0;
    end
    test_reset();
    test_basic();
    test_underflow();
    test_borrow_in();
    test_overflow();
    test_backpressure();
    test_reset_mid_run();
    test_chunk_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, errCount);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Multi-cycle, parametrised WIDTH-bit subtractor that computes `a - b - bin` in CHUNK-bit slices, LSB slice first, one slice per clock. A registered borrow chains between slices. Operands enter and results leave through valid/ready handshakes. It is the datapath-width-scalable successor to the single-bit subtractor cells, for use where a full-width borrow chain would not close timing.

## Interface
Parameters:
- WIDTH, 16, operand and result width; must be a multiple of CHUNK.
- CHUNK, 4, bits processed per cycle; 1 ≤ CHUNK ≤ WIDTH.
- NCHUNK (localparam) = WIDTH/CHUNK, cycles per operation.

Ports (clock and reset first):
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand bundle valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- bin  input  1  borrow-in.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- diff  output  WIDTH  (a - b - bin) mod 2^WIDTH.
- bout  output  1  unsigned borrow-out: 1 iff a < b + bin.
- ovf  output  1  two's-complement overflow of the signed subtraction.

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid & in_ready: latch a, b and bin into internal registers, clear the slice index, and go to RUN.
  - a, b and bin are don't-care after the accept edge.
- RUN:
  - in_ready=0, out_valid=0.
  - Each cycle, slice k (bits k*CHUNK+CHUNK-1 : k*CHUNK) computes a_k - b_k - borrow_reg. Its CHUNK difference bits are written into the diff register, and its borrow-out goes to borrow_reg.
  - borrow_reg is loaded from bin on accept.
  - After slice NCHUNK-1 is written, go to DONE.
- DONE:
  - out_valid=1. diff, bout and ovf are held stable.
  - bout = final borrow_reg.
  - ovf = (a[MSB] ^ b[MSB]) & (a[MSB] ^ diff[MSB]), using the latched operands.
  - On out_valid & out_ready: go to IDLE.
  - in_valid is ignored; there is no overlap of operations.
- Arithmetic is pure modulo 2^WIDTH. bin participates only in slice 0.

## Timing
- Reset (async assert, sync-released by the system): state=IDLE, in_ready=1, out_valid=0, diff=0, bout=0, ovf=0, and all internal registers cleared.
- Latency: accept at edge E0 gives out_valid=1 after edge E(NCHUNK), i.e. NCHUNK cycles. For WIDTH=16, CHUNK=4 this is 4 cycles.
- Throughput: at best one result per NCHUNK+2 cycles:
  - accept edge, then NCHUNK RUN edges, then the result-handshake edge.
  - in_ready rises the cycle after the output handshake.
- Backpressure: out_ready low holds DONE indefinitely with outputs unchanged.
- Reset asserted mid-RUN or mid-DONE: immediate return to IDLE with reset values. The partial result is discarded and no out_valid pulse occurs.
- CHUNK=WIDTH: RUN lasts exactly 1 cycle.
- CHUNK=1: RUN lasts WIDTH cycles.

## Structure
- Shared package `sub_pkg`:
  - state encoding constants ST_IDLE, ST_RUN, ST_DONE;
  - a width-of-index helper (clog2) used to size the slice counter.
- One sub-module, `chunk_sub`:
  - parametrised CHUNK-bit combinational slice with inputs x, y, bi and outputs d, bo;
  - built as a ripple of full-subtractor cells;
  - instantiated once and muxed by slice index. It is not replicated NCHUNK times.
- Top holds the FSM, slice counter, operand registers, borrow_reg, diff register and flags.

## Test plan
Directed scenarios, with WIDTH=16 and CHUNK=4 unless noted:
1. **Basic subtraction.** a=0x1234, b=0x0234, bin=0. Required: diff=0x1000, bout=0, ovf=0, with out_valid exactly 4 cycles after the accept edge.
2. **Underflow.** a=0x0000, b=0x0001, bin=0. Required: diff=0xFFFF, bout=1, ovf=0.
3. **Borrow-in.** a=0x0005, b=0x0005, bin=1. Required: diff=0xFFFF, bout=1.
4. **Signed overflow.** a=0x8000, b=0x0001. Required: diff=0x7FFF, bout=0, ovf=1.
5. **Backpressure.** Hold out_ready=0 for 5 cycles in DONE while pulsing in_valid with new operands. Required: outputs stay constant, in_ready=0 throughout, no second accept; after out_ready=1, in_ready=1 on the next cycle.
6. **Reset and parameter sweep.**
   - Assert rst_n=0 during the 2nd RUN cycle. Required: in_ready=1, out_valid=0, diff=0 immediately; the next operation 0x00FF-0x000F gives 0x00F0.
   - Repeat scenario 1 with CHUNK=1 (16-cycle latency) and CHUNK=16 (1-cycle latency).
